// File: rtl/uart_bus_bridge_pkg.sv
// Shared command/response codes, FSM state types and baud divisor helper
// for the UART-driven bus initiator.
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    F_CMD  = 3'd0,
    F_ADDR = 3'd1,
    F_DATA = 3'd2,
    F_EXEC = 3'd3,
    F_RESP = 3'd4
  } frame_state_e;

  typedef enum logic [2:0] {
    R_HUNT   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_STOP   = 3'd3,
    R_WAITHI = 3'd4
  } rx_state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq / baud) - 1;
  endfunction

endpackage

// File: rtl/uart_bridge_tx.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit. A start request
// on the final stop-bit cycle chains the next byte with no idle gap.
module uart_bridge_tx #(
  parameter int BAUD_DIV = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       uart_tx,
  output logic       done
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_TC = BW'(BAUD_DIV);

  logic          active_q;
  logic [BW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;
  logic          tx_q;

  assign done    = active_q && (bit_q == 4'd9) && (cnt_q == BAUD_TC);
  assign uart_tx = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 9'h1FF;
      tx_q     <= 1'b1;
    end else if (start && (!active_q || done)) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      shift_q  <= {1'b1, din};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (cnt_q == BAUD_TC) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      tx_q <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator: decodes 'W'/'R' command frames from the serial line,
// issues a single bus write or read, and answers with 'K', the read word, or '?'.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115_200,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BAUD_TC   = BW'(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV >> 1);
  localparam logic [TW-1:0] TO_TC     = TW'(TIMEOUT_CYCLES);

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e     rx_st_q;
  logic [BW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_tick_s, rx_done_s, rx_ferr_s;

  frame_state_e  fs_q;
  logic          is_wr_q;
  logic [1:0]    byte_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [31:0]   bus_addr_q, bus_wdata_q, resp_q;
  logic          bus_we_q, bus_re_q, busy_q, frame_err_q;
  logic [1:0]    resp_idx_q, resp_last_q, resp_nidx_s;
  logic          timeout_s, tx_start_s, tx_done_s;
  logic [7:0]    tx_din_s;

  assign rx_tick_s = (rx_cnt_q == BAUD_TC);
  assign rx_done_s = (rx_st_q == R_STOP) && rx_tick_s && rx_s2_q;
  assign rx_ferr_s = (rx_st_q == R_STOP) && rx_tick_s && !rx_s2_q;
  assign timeout_s = ((fs_q == F_ADDR) || (fs_q == F_DATA)) && (to_cnt_q == TO_TC);

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

  // Receiver: start recheck at half a bit, then sample once per bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_HUNT;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_st_q)
        R_HUNT: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_st_q <= R_START;
        end
        R_START: begin
          if (rx_cnt_q == BAUD_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= 3'd0;
            rx_st_q  <= rx_s2_q ? R_HUNT : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_tick_s) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_bit_q <= 3'd0;
              rx_st_q  <= R_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_tick_s) begin
            rx_cnt_q <= '0;
            rx_st_q  <= rx_s2_q ? R_HUNT : R_WAITHI;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_WAITHI: begin
          rx_cnt_q <= '0;
          if (rx_s2_q) rx_st_q <= R_HUNT;
        end
        default: rx_st_q <= R_HUNT;
      endcase
    end
  end

  // First response byte is launched from EXEC (or CMD for '?'); later ones chain on done.
  always_comb begin
    tx_start_s  = 1'b0;
    tx_din_s    = RSP_ERR;
    resp_nidx_s = resp_idx_q + 2'd1;
    case (fs_q)
      F_CMD: begin
        if (rx_done_s && (rx_shift_q != CMD_WR) && (rx_shift_q != CMD_RD)) begin
          tx_start_s = 1'b1;
        end else begin
          tx_start_s = 1'b0;
        end
      end
      F_EXEC: begin
        tx_start_s = 1'b1;
        tx_din_s   = is_wr_q ? RSP_OK : bus_rdata[7:0];
      end
      F_RESP: begin
        if (tx_done_s && (resp_idx_q != resp_last_q)) begin
          tx_start_s = 1'b1;
          tx_din_s   = resp_q[{resp_nidx_s, 3'b000} +: 8];
        end else begin
          tx_start_s = 1'b0;
        end
      end
      default: tx_start_s = 1'b0;
    endcase
  end

  // Frame sequencer; the timeout counter restarts at every accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q        <= F_CMD;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= 2'd0;
      to_cnt_q    <= '0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      resp_q      <= 32'h0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      resp_idx_q  <= 2'd0;
      resp_last_q <= 2'd0;
    end else begin
      frame_err_q <= rx_ferr_s || timeout_s;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      case (fs_q)
        F_CMD: begin
          byte_cnt_q <= 2'd0;
          to_cnt_q   <= '0;
          if (rx_done_s) begin
            busy_q <= 1'b1;
            if ((rx_shift_q == CMD_WR) || (rx_shift_q == CMD_RD)) begin
              is_wr_q  <= (rx_shift_q == CMD_WR);
              to_cnt_q <= TW'(1);
              fs_q     <= F_ADDR;
            end else begin
              resp_idx_q  <= 2'd0;
              resp_last_q <= 2'd0;
              fs_q        <= F_RESP;
            end
          end
        end
        F_ADDR, F_DATA: begin
          if (timeout_s || rx_ferr_s) begin
            fs_q     <= F_CMD;
            busy_q   <= 1'b0;
            to_cnt_q <= '0;
          end else if (rx_done_s) begin
            to_cnt_q <= TW'(1);
            if (fs_q == F_ADDR) bus_addr_q[{byte_cnt_q, 3'b000} +: 8] <= rx_shift_q;
            else bus_wdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_shift_q;
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= 2'd0;
              if ((fs_q == F_ADDR) && is_wr_q) begin
                fs_q <= F_DATA;
              end else begin
                fs_q     <= F_EXEC;
                bus_we_q <= is_wr_q;
                bus_re_q <= !is_wr_q;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        F_EXEC: begin
          fs_q        <= F_RESP;
          resp_idx_q  <= 2'd0;
          resp_last_q <= is_wr_q ? 2'd0 : 2'd3;
          if (!is_wr_q) resp_q <= bus_rdata;
        end
        F_RESP: begin
          if (tx_done_s) begin
            if (resp_idx_q == resp_last_q) begin
              fs_q   <= F_CMD;
              busy_q <= 1'b0;
            end else begin
              resp_idx_q <= resp_nidx_s;
            end
          end
        end
        default: fs_q <= F_CMD;
      endcase
    end
  end

  uart_bridge_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start_s),
    .din     (tx_din_s),
    .uart_tx (uart_tx),
    .done    (tx_done_s)
  );

endmodule
